// File: rtl/fs_nbits_seq.sv
// Multi-cycle signed subtractor: a - b - bin on sign-extended operands,
// resolved CHUNK bits per clock with optional approximate low bits.
module fs_nbits_seq #(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0,
  parameter int CHUNK       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  input  logic            approx_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE:0]   diff,
  output logic            bout
);

  localparam int W      = SIZE + 1;
  localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  diff_r;
  logic [W-1:0]  diff_nxt;
  logic          br_r;
  logic          br_nxt;
  logic          approx_r;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(NCHUNK - 1));
  assign diff = diff_r;
  assign bout = br_r;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only bits of the current chunk change; borrow re-enters at chunk start.
  always_comb begin
    logic br;
    logic ai;
    logic bi;
    logic apx;
    diff_nxt = diff_r;
    br_nxt   = br_r;
    br       = br_r;
    ai       = 1'b0;
    bi       = 1'b0;
    apx      = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i % CHUNK == 0) br = br_r;
      if (cnt == CW'(i / CHUNK)) begin
        ai  = a_r[i];
        bi  = b_r[i];
        apx = approx_r && (i < APPROX_BITS);
        if (apx) begin
          diff_nxt[i] = ai ^ bi;
          br          = ~ai & bi;
        end else begin
          diff_nxt[i] = ai ^ bi ^ br;
          br          = (~ai & bi) | (~(ai ^ bi) & br);
        end
        if ((i % CHUNK == CHUNK - 1) || (i == W - 1)) br_nxt = br;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      diff_r   <= '0;
      br_r     <= 1'b0;
      approx_r <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= {a[SIZE-1], a};
            b_r      <= {b[SIZE-1], b};
            br_r     <= bin;
            approx_r <= approx_en;
            cnt      <= '0;
          end
        end
        BUSY: begin
          diff_r <= diff_nxt;
          br_r   <= br_nxt;
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
